qsys_sysid_regs: RTL and testbench

Parametrised system-identification register block for the Nios II Qsys systems: an Avalon-MM slave that returns the system ID, build timestamp, a capability word, a table of build-time info words, a software scratch register and a 64-bit free-running uptime counter with coherent snapshot reads. It sits on the CPU data master's control bus; the boot and driver code uses it to confirm that the software image matches the loaded hardware.

---
 rtl/qsys_sysid_regs_if.sv | 23 ++
 rtl/qsys_sysid_regs.sv | 110 +++++++++++
 tb/tb_qsys_sysid_regs.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/qsys_sysid_regs_if.sv
// Avalon-MM bus bundle for the system-ID register block.
// The CPU side uses the master modport and the register block uses the slave modport.
interface qsys_sysid_regs_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/qsys_sysid_regs.sv
// System-identification register block (Avalon-MM slave).
// It returns the ID, the build timestamp, the capability word and the info table.
// It also holds a software scratch word and a 64-bit uptime counter.
// Reading the LO word of the counter latches the HI word into a snapshot, so a LO read
// followed by a HI read gives a coherent 64-bit value. Read latency is fixed at one cycle.
module qsys_sysid_regs #(
  parameter logic [31:0]            ID        = 32'h0000_0002,
  parameter logic [31:0]            TIMESTAMP = 32'h5C37_5A74,
  parameter int                     ADDR_W    = 4,
  parameter int                     NUM_INFO  = 4,
  parameter logic [32*NUM_INFO-1:0] INFO_INIT = {NUM_INFO{32'h0}},
  parameter logic [7:0]             VERSION   = 8'h02
) (
  input  logic                  clock,
  input  logic                  reset_n,
  qsys_sysid_regs_if.slave      bus
);

  localparam logic [31:0] CAPS = {8'h00, 8'(ADDR_W), 8'(NUM_INFO), VERSION};
  localparam logic [31:0] INFO_END = 32'(8 + NUM_INFO);

  logic [31:0] addr_ext;
  logic [31:0] info_idx;
  logic        wr_en;
  logic        cnt_clr;

  logic [31:0] rdata_d, rdata_q;
  logic        rvld_q;
  logic [31:0] scratch_d, scratch_q;
  logic [63:0] cnt_d, cnt_q;
  logic [31:0] hi_snap_d, hi_snap_q;

  assign addr_ext = 32'(bus.address);
  assign info_idx = addr_ext - 32'd8;

  // A write that arrives together with a read is dropped, so the read wins.
  assign wr_en   = bus.write & ~bus.read;
  assign cnt_clr = wr_en & (addr_ext == 32'd6) & bus.writedata[0];

  // Read-data mux: unmapped, write-only and reserved words read as zero.
  always_comb begin
    rdata_d = '0;
    case (addr_ext)
      32'd0:   rdata_d = ID;
      32'd1:   rdata_d = TIMESTAMP;
      32'd2:   rdata_d = CAPS;
      32'd3:   rdata_d = scratch_q;
      32'd4:   rdata_d = cnt_q[31:0];
      32'd5:   rdata_d = hi_snap_q;
      32'd6:   rdata_d = '0;
      32'd7:   rdata_d = '0;
      default: begin
        if (addr_ext >= 32'd8 && addr_ext < INFO_END) begin
          rdata_d = INFO_INIT[info_idx*32 +: 32];
        end
      end
    endcase
  end

  // Next state for the scratch register, the uptime counter and the HI snapshot.
  always_comb begin
    scratch_d = scratch_q;
    if (wr_en && (addr_ext == 32'd3)) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteenable[b]) begin
          scratch_d[8*b +: 8] = bus.writedata[8*b +: 8];
        end
      end
    end

    cnt_d = cnt_clr ? 64'd0 : cnt_q + 64'd1;

    hi_snap_d = hi_snap_q;
    if (cnt_clr) begin
      hi_snap_d = '0;
    end else if (bus.read && (addr_ext == 32'd4)) begin
      hi_snap_d = cnt_q[63:32];
    end
  end

  // Read response stage: a read sampled at this edge is answered in the following cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      rvld_q <= bus.read;
      if (bus.read) begin
        rdata_q <= rdata_d;
      end
    end
  end

  // State stage: scratch, free-running uptime counter and its HI snapshot.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scratch_q <= '0;
      cnt_q     <= '0;
      hi_snap_q <= '0;
    end else begin
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      hi_snap_q <= hi_snap_d;
    end
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvld_q;

endmodule

// File: tb/tb_qsys_sysid_regs.sv
// Scoreboard bench for qsys_sysid_regs.
// Read expectations are queued when a read is driven and are compared when readdatavalid returns.
module tb_qsys_sysid_regs;

  localparam logic [127:0] INFO_P = {32'h44, 32'h33, 32'h22, 32'h11};

  logic clock;
  logic reset_n;

  qsys_sysid_regs_if #(.ADDR_W(4)) bus ();

  qsys_sysid_regs #(
    .NUM_INFO  (4),
    .INFO_INIT (INFO_P)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_vec;
  int          n_miss;
  logic [31:0] exp_q[$];
  logic [63:0] m_cnt;
  logic [31:0] m_hi;
  logic [31:0] m_scr;
  logic [31:0] info_tab [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock: update the reference model, then check the response after the edge.
  task automatic tick();
    logic       exp_vld;
    logic       clr;
    logic [31:0] e;
    exp_vld = bus.read && reset_n;
    clr = 1'b0;
    if (!reset_n) begin
      m_cnt = '0;
      m_hi  = '0;
      m_scr = '0;
    end else begin
      if (bus.read) begin
        if (bus.address == 4'd4) m_hi = m_cnt[63:32];
      end else if (bus.write) begin
        if (bus.address == 4'd3) begin
          for (int b = 0; b < 4; b++)
            if (bus.byteenable[b]) m_scr[8*b +: 8] = bus.writedata[8*b +: 8];
        end
        if (bus.address == 4'd6 && bus.writedata[0]) begin
          clr = 1'b1;
          m_hi = '0;
        end
      end
      m_cnt = clr ? 64'd0 : m_cnt + 64'd1;
    end
    @(posedge clock);
    @(negedge clock);
    check_eq("readdatavalid", 64'(bus.readdatavalid), 64'(exp_vld));
    if (exp_vld) begin
      if (exp_q.size() == 0) begin
        check_eq("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("readdata", 64'(bus.readdata), 64'(e));
      end
    end
  endtask

  function automatic logic [31:0] expect_word(input logic [3:0] a);
    case (a)
      4'd0:    return 32'h0000_0002;
      4'd1:    return 32'h5C37_5A74;
      4'd2:    return 32'h0004_0402;
      4'd3:    return m_scr;
      4'd4:    return m_cnt[31:0];
      4'd5:    return m_hi;
      4'd8, 4'd9, 4'd10, 4'd11: return info_tab[a - 4'd8];
      default: return 32'h0;
    endcase
  endfunction

  task automatic rd(input logic [3:0] a);
    bus.address = a;
    bus.read    = 1'b1;
    bus.write   = 1'b0;
    if (reset_n) exp_q.push_back(expect_word(a));
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address    = a;
    bus.read       = 1'b0;
    bus.write      = 1'b1;
    bus.writedata  = d;
    bus.byteenable = be;
    tick();
  endtask

  task automatic rw(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address    = a;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.writedata  = d;
    bus.byteenable = be;
    if (reset_n) exp_q.push_back(expect_word(a));
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.read  = 1'b0;
      bus.write = 1'b0;
      tick();
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    m_cnt  = '0;
    m_hi   = '0;
    m_scr  = '0;
    info_tab[0] = 32'h11;
    info_tab[1] = 32'h22;
    info_tab[2] = 32'h33;
    info_tab[3] = 32'h44;
    bus.address    = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
    bus.byteenable = '0;
    reset_n        = 1'b0;

    @(negedge clock);
    idle(3);
    check_eq("reset_readdata", 64'(bus.readdata), 64'd0);
    reset_n = 1'b1;

    // ID, timestamp and CAPS, back to back
    rd(4'd0);
    rd(4'd1);
    rd(4'd2);
    idle(1);

    // scratch byte-lane writes
    wr(4'd3, 32'hDEAD_BEEF, 4'b1111);
    wr(4'd3, 32'h0000_1200, 4'b0010);
    rd(4'd3);
    check_eq("scratch_model", 64'(m_scr), 64'h0000_0000_DEAD_12EF);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    rd(4'd3);

    // info table, out-of-range words, writes to RO words
    for (int a = 8; a < 16; a++) rd(4'(a));
    wr(4'd8, 32'hFFFF_FFFF, 4'b1111);
    rd(4'd8);
    wr(4'd0, 32'h1234_5678, 4'b1111);
    wr(4'd7, 32'hFFFF_FFFF, 4'b1111);
    rd(4'd0);
    rd(4'd7);
    rd(4'd6);

    // coherent uptime snapshot across a LO word wrap
    idle(1);
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 64'h0000_0000_FFFF_FFFE;
    rd(4'd4);
    idle(4);
    rd(4'd5);
    rd(4'd4);
    rd(4'd5);
    check_eq("hi_after_wrap", 64'(m_hi), 64'd1);

    // CTRL clear, then a CTRL write with bit 0 low
    wr(4'd6, 32'h1, 4'b1111);
    idle(1);
    rd(4'd4);
    check_eq("lo_after_clear", m_cnt, 64'd2);
    rd(4'd5);
    idle(3);
    wr(4'd6, 32'h0, 4'b1111);
    rd(4'd4);
    rd(4'd5);

    // simultaneous read and write: write dropped
    wr(4'd3, 32'hCAFE_F00D, 4'b1111);
    rw(4'd3, 32'h0000_0055, 4'b1111);
    rd(4'd3);
    rw(4'd6, 32'h1, 4'b1111);
    rd(4'd4);

    // reset arriving with a read in flight
    bus.address = 4'd0;
    bus.read    = 1'b1;
    bus.write   = 1'b0;
    reset_n     = 1'b0;
    tick();
    check_eq("rst_mid_read_data", 64'(bus.readdata), 64'd0);
    reset_n = 1'b1;
    rd(4'd1);
    reset_n = 1'b0;
    idle(1);
    check_eq("rst_after_read_data", 64'(bus.readdata), 64'd0);
    reset_n = 1'b1;
    idle(2);
    rd(4'd4);

    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
